// File: rtl/id_ex_ctrl.sv
// ---------------------------------------------------------------------------
// id_ex_ctrl
//   Decode -> execute handshake controller. Detects load-use hazards against
//   the instruction held in ID/EX and inserts LOAD_LAT bubbles. Redirects
//   (flush) kill the ID/EX contents. Execute back-pressure (ex_ready=0)
//   freezes everything. Also keeps a saturating count of stalled decode
//   cycles.
//
// Parameters
//   LOAD_LAT  bubbles inserted per load-use hazard (1..7)
//   CNT_W     width of the stall performance counter
//
// Ports
//   clk, rst                      clock, async active-high reset
//   dec_valid                     decode holds a valid instruction
//   dec_srcReg1/2, dec_useRs1/2   decoded sources and their use flags
//   ex_memRead, ex_destReg        control/dest fields of the ID/EX register
//   ex_ready                      execute accepts ID/EX this cycle
//   flush                         kill decode and ID/EX contents
//   dec_ready                     decode instruction consumed (comb)
//   idex_en                       ID/EX load enable (comb)
//   idex_bubble                   zero ID/EX control fields on load (comb)
//   ex_valid                      ID/EX holds a real instruction (reg)
//   stall_cnt                     saturating stalled-decode counter (reg)
//   state                         FSM state: 00 RUN, 01 HAZ, 10 FLUSH (reg)
// ---------------------------------------------------------------------------
module id_ex_ctrl #(
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dec_valid,
  input  logic [4:0]       dec_srcReg1,
  input  logic [4:0]       dec_srcReg2,
  input  logic             dec_useRs1,
  input  logic             dec_useRs2,
  input  logic             ex_memRead,
  input  logic [4:0]       ex_destReg,
  input  logic             ex_ready,
  input  logic             flush,
  output logic             dec_ready,
  output logic             idex_en,
  output logic             idex_bubble,
  output logic             ex_valid,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    S_RUN   = 2'b00,
    S_HAZ   = 2'b01,
    S_FLUSH = 2'b10
  } state_t;

  // Bubbles still owed after the first one, which is issued from RUN.
  localparam logic [2:0] LAT_M1 = 3'(LOAD_LAT - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [2:0]       r_hcnt;
  logic [2:0]       w_hcnt_nxt;
  logic             r_ex_valid;
  logic             w_ex_valid_nxt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_haz;
  logic             w_rs1_hit;
  logic             w_rs2_hit;
  logic             w_stall;

  // Only a real load in ID/EX can cause a hazard; x0 is never a dependency.
  assign w_rs1_hit = dec_useRs1 & (dec_srcReg1 == ex_destReg);
  assign w_rs2_hit = dec_useRs2 & (dec_srcReg2 == ex_destReg);
  assign w_haz     = dec_valid & r_ex_valid & ex_memRead &
                     (ex_destReg != 5'd0) & (w_rs1_hit | w_rs2_hit);

  always_comb begin
    w_state_nxt    = r_state;
    w_hcnt_nxt     = r_hcnt;
    w_ex_valid_nxt = r_ex_valid;
    dec_ready      = 1'b0;
    idex_en        = 1'b0;
    idex_bubble    = 1'b0;

    if (flush) begin
      idex_en        = 1'b1;
      idex_bubble    = 1'b1;
      w_ex_valid_nxt = 1'b0;
      w_state_nxt    = S_FLUSH;
      w_hcnt_nxt     = 3'd0;
    end else if (!ex_ready) begin
      // Execute is back-pressuring: hold everything, consume nothing.
    end else begin
      case (r_state)
        S_HAZ: begin
          idex_en        = 1'b1;
          idex_bubble    = 1'b1;
          w_ex_valid_nxt = 1'b0;
          // Counter value is the number of HAZ cycles left including this one.
          if (r_hcnt <= 3'd1) begin
            w_hcnt_nxt  = 3'd0;
            w_state_nxt = S_RUN;
          end else begin
            w_hcnt_nxt  = r_hcnt - 3'd1;
          end
        end
        S_FLUSH: begin
          idex_en        = 1'b1;
          idex_bubble    = 1'b1;
          w_ex_valid_nxt = 1'b0;
          w_hcnt_nxt     = 3'd0;
          w_state_nxt    = S_RUN;
        end
        default: begin
          idex_en = 1'b1;
          if (w_haz) begin
            idex_bubble    = 1'b1;
            w_ex_valid_nxt = 1'b0;
            if (LOAD_LAT > 1) begin
              w_state_nxt = S_HAZ;
              w_hcnt_nxt  = LAT_M1;
            end
          end else begin
            dec_ready      = dec_valid;
            w_ex_valid_nxt = dec_valid;
          end
        end
      endcase
    end
  end

  assign w_stall = dec_valid & ~dec_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_RUN;
      r_hcnt     <= 3'd0;
      r_ex_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_hcnt     <= w_hcnt_nxt;
      r_ex_valid <= w_ex_valid_nxt;
    end
  end

  // Saturating: once all-ones the counter sticks until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall && !(&r_stall_cnt)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign ex_valid  = r_ex_valid;
  assign stall_cnt = r_stall_cnt;
  assign state     = r_state;

endmodule

// File: tb/tb_id_ex_ctrl.sv
module tb_id_ex_ctrl;

  typedef struct {
    bit       dv;
    bit [4:0] s1;
    bit [4:0] s2;
    bit       u1;
    bit       u2;
    bit       mr;
    bit [4:0] dst;
    bit       exr;
    bit       fl;
  } vin_t;

  typedef struct {
    vin_t in;
    bit   rdy;
    bit   en;
    bit   bub;
    bit   exv;
    int   st;
    int   sc;
  } vec_t;

  // Model: bubbles still owed, whether a flush cycle is pending, ID/EX validity.
  typedef struct {
    int bl;
    bit fp;
    bit exv;
    int sc;
  } mdl_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       dv, u1, u2, mr, exr, fl;
  logic [4:0] s1, s2, dst;
  logic       rdy [2];
  logic       en  [2];
  logic       bub [2];
  logic       exv [2];
  logic [1:0] st  [2];
  logic [15:0] sc0;
  logic [3:0]  sc1;

  int   n_chk = 0;
  int   n_fail = 0;
  mdl_t m [2];
  int   ll   [2] = '{1, 3};
  int   smax [2] = '{65535, 15};
  vec_t tbl [15];

  always #5 clk = ~clk;

  id_ex_ctrl #(.LOAD_LAT(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .dec_valid(dv), .dec_srcReg1(s1), .dec_srcReg2(s2),
    .dec_useRs1(u1), .dec_useRs2(u2), .ex_memRead(mr), .ex_destReg(dst),
    .ex_ready(exr), .flush(fl), .dec_ready(rdy[0]), .idex_en(en[0]),
    .idex_bubble(bub[0]), .ex_valid(exv[0]), .stall_cnt(sc0), .state(st[0]));

  id_ex_ctrl #(.LOAD_LAT(3), .CNT_W(4)) dut3 (
    .clk(clk), .rst(rst), .dec_valid(dv), .dec_srcReg1(s1), .dec_srcReg2(s2),
    .dec_useRs1(u1), .dec_useRs2(u2), .ex_memRead(mr), .ex_destReg(dst),
    .ex_ready(exr), .flush(fl), .dec_ready(rdy[1]), .idex_en(en[1]),
    .idex_bubble(bub[1]), .ex_valid(exv[1]), .stall_cnt(sc1), .state(st[1]));

  function automatic int sc_of(input int k);
    return (k == 0) ? int'(sc0) : int'(sc1);
  endfunction

  function automatic vin_t vi(input bit d, input int a, input bit ua, input int b,
                              input bit ub, input bit r, input int t, input bit e,
                              input bit f);
    vin_t v;
    v.dv = d; v.s1 = 5'(a); v.u1 = ua; v.s2 = 5'(b); v.u2 = ub;
    v.mr = r; v.dst = 5'(t); v.exr = e; v.fl = f;
    return v;
  endfunction

  function automatic vec_t mk(input vin_t v, input bit r, input bit e, input bit b,
                              input bit x, input int s, input int c);
    vec_t t;
    t.in = v; t.rdy = r; t.en = e; t.bub = b; t.exv = x; t.st = s; t.sc = c;
    return t;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Expected combinational outputs from the priority rules.
  task automatic mcomb(input mdl_t s, input vin_t v, output bit r, output bit e,
                       output bit b);
    bit haz;
    haz = v.dv && s.exv && v.mr && (v.dst != 0) &&
          ((v.u1 && v.s1 == v.dst) || (v.u2 && v.s2 == v.dst));
    r = 0; e = 1; b = 1;
    if (v.fl) begin
    end else if (!v.exr) begin
      e = 0; b = 0;
    end else if (s.fp || s.bl > 0 || haz) begin
    end else begin
      b = 0; r = v.dv;
    end
    if (!v.exr && !v.fl) e = 0;
  endtask

  task automatic mstep(input int k, input vin_t v);
    bit r, e, b, haz;
    mcomb(m[k], v, r, e, b);
    haz = v.dv && m[k].exv && v.mr && (v.dst != 0) &&
          ((v.u1 && v.s1 == v.dst) || (v.u2 && v.s2 == v.dst));
    if (v.dv && !r && m[k].sc < smax[k]) m[k].sc++;
    if (v.fl) begin
      m[k].exv = 0; m[k].fp = 1; m[k].bl = 0;
    end else if (!v.exr) begin
    end else if (m[k].fp) begin
      m[k].fp = 0; m[k].exv = 0;
    end else if (m[k].bl > 0) begin
      m[k].bl--; m[k].exv = 0;
    end else if (haz) begin
      m[k].bl = ll[k] - 1; m[k].exv = 0;
    end else begin
      m[k].exv = v.dv;
    end
  endtask

  task automatic mreset();
    for (int k = 0; k < 2; k++) begin
      m[k].bl = 0; m[k].fp = 0; m[k].exv = 0; m[k].sc = 0;
    end
  endtask

  // Drive one cycle's inputs, check both DUTs against the model before the
  // edge, advance the model. Caller ticks to the next negedge afterwards.
  task automatic cyc(input vin_t v);
    bit r, e, b;
    int es;
    dv = v.dv; s1 = v.s1; s2 = v.s2; u1 = v.u1; u2 = v.u2;
    mr = v.mr; dst = v.dst; exr = v.exr; fl = v.fl;
    #2;
    for (int k = 0; k < 2; k++) begin
      mcomb(m[k], v, r, e, b);
      es = m[k].fp ? 2 : (m[k].bl > 0 ? 1 : 0);
      chk($sformatf("mdl_rdy%0d", k), int'(rdy[k]), int'(r));
      chk($sformatf("mdl_en%0d", k), int'(en[k]), int'(e));
      if (e) chk($sformatf("mdl_bub%0d", k), int'(bub[k]), int'(b));
      chk($sformatf("mdl_exv%0d", k), int'(exv[k]), int'(m[k].exv));
      chk($sformatf("mdl_st%0d", k), int'(st[k]), es);
      chk($sformatf("mdl_sc%0d", k), sc_of(k), m[k].sc);
      if (rdy[k] && !v.dv) chk($sformatf("rdy_wo_valid%0d", k), 1, 0);
    end
    for (int k = 0; k < 2; k++) mstep(k, v);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Reset asserted between edges; values must clear with no clock edge.
  task automatic do_reset();
    dv = 1; s1 = 0; s2 = 0; u1 = 1; u2 = 0; mr = 0; dst = 0; exr = 1; fl = 0;
    rst = 1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_st%0d", k), int'(st[k]), 0);
      chk($sformatf("rst_exv%0d", k), int'(exv[k]), 0);
      chk($sformatf("rst_sc%0d", k), sc_of(k), 0);
      chk($sformatf("rst_rdy%0d", k), int'(rdy[k]), 1);
      chk($sformatf("rst_bub%0d", k), int'(bub[k]), 0);
    end
    mreset();
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vin_t ISS, LHZ, v;

    // Expected values apply to dut1 (LOAD_LAT=1, CNT_W=16) from reset.
    tbl[0]  = mk(vi(1,5,1,0,0,0,0,1,0), 1,1,0,0,0,0);
    tbl[1]  = mk(vi(1,5,1,0,0,1,5,1,0), 0,1,1,1,0,0);
    tbl[2]  = mk(vi(1,5,1,0,0,1,5,1,0), 1,1,0,0,0,1);
    tbl[3]  = mk(vi(1,0,1,0,1,1,0,1,0), 1,1,0,1,0,1);
    tbl[4]  = mk(vi(1,0,1,0,1,1,0,1,0), 1,1,0,1,0,1);
    tbl[5]  = mk(vi(1,3,1,7,1,1,7,1,0), 0,1,1,1,0,1);
    tbl[6]  = mk(vi(1,7,0,7,0,1,7,1,0), 1,1,0,0,0,2);
    tbl[7]  = mk(vi(1,7,0,7,0,1,7,1,0), 1,1,0,1,0,2);
    tbl[8]  = mk(vi(1,7,1,0,0,0,7,1,0), 1,1,0,1,0,2);
    tbl[9]  = mk(vi(0,7,1,0,0,0,7,1,0), 0,1,0,1,0,2);
    tbl[10] = mk(vi(1,7,1,0,0,0,7,0,0), 0,0,0,0,0,2);
    tbl[11] = mk(vi(1,7,1,0,0,0,7,0,0), 0,0,0,0,0,3);
    tbl[12] = mk(vi(1,7,1,0,0,0,7,1,1), 0,1,1,0,0,4);
    tbl[13] = mk(vi(1,1,1,0,0,0,0,1,0), 0,1,1,0,2,5);
    tbl[14] = mk(vi(1,1,1,0,0,0,0,1,0), 1,1,0,0,0,6);
    ISS = vi(1,5,1,0,0,0,0,1,0);
    LHZ = vi(1,5,1,0,0,1,5,1,0);

    dv = 0; s1 = 0; s2 = 0; u1 = 0; u2 = 0; mr = 0; dst = 0; exr = 1; fl = 0;
    mreset();
    tick();
    do_reset();

    for (int i = 0; i < 15; i++) begin
      cyc(tbl[i].in);
      chk($sformatf("tbl%0d_rdy", i), int'(rdy[0]), int'(tbl[i].rdy));
      chk($sformatf("tbl%0d_en", i), int'(en[0]), int'(tbl[i].en));
      if (tbl[i].en) chk($sformatf("tbl%0d_bub", i), int'(bub[0]), int'(tbl[i].bub));
      chk($sformatf("tbl%0d_exv", i), int'(exv[0]), int'(tbl[i].exv));
      chk($sformatf("tbl%0d_st", i), int'(st[0]), tbl[i].st);
      chk($sformatf("tbl%0d_sc", i), int'(sc0), tbl[i].sc);
      tick();
    end

    // LOAD_LAT=3: exactly three bubbles, RUN->HAZ->HAZ->RUN.
    do_reset();
    cyc(ISS); tick();
    cyc(LHZ); chk("l3_st0", int'(st[1]), 0); chk("l3_bub0", int'(bub[1]), 1); tick();
    cyc(LHZ); chk("l3_st1", int'(st[1]), 1); chk("l3_bub1", int'(bub[1]), 1); tick();
    cyc(LHZ); chk("l3_st2", int'(st[1]), 1); chk("l3_rdy2", int'(rdy[1]), 0); tick();
    cyc(LHZ); chk("l3_st3", int'(st[1]), 0); chk("l3_rdy3", int'(rdy[1]), 1);
    chk("l3_sc", int'(sc1), 3); tick();

    // Back-pressure inside HAZ freezes the bubble countdown.
    do_reset();
    cyc(ISS); tick();
    cyc(LHZ); tick();
    cyc(LHZ); tick();
    v = LHZ; v.exr = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(v);
      chk("bp_st", int'(st[1]), 1); chk("bp_en", int'(en[1]), 0);
      chk("bp_exv1", int'(exv[0]), 1);
      tick();
    end
    cyc(LHZ); chk("bp_st_after", int'(st[1]), 1); chk("bp_bub", int'(bub[1]), 1); tick();
    cyc(LHZ); chk("bp_run", int'(st[1]), 0); chk("bp_rdy", int'(rdy[1]), 1);
    chk("bp_sc3", int'(sc1), 7); chk("bp_sc1", int'(sc0), 6); tick();

    // Flush inside HAZ (counter 2): one FLUSH cycle then clean RUN.
    do_reset();
    cyc(ISS); tick();
    cyc(LHZ); tick();
    v = LHZ; v.fl = 1;
    cyc(v); chk("fl_inhaz", int'(st[1]), 1); chk("fl_bub", int'(bub[1]), 1); tick();
    cyc(ISS); chk("fl_st", int'(st[1]), 2); chk("fl_exv", int'(exv[1]), 0);
    chk("fl_rdy", int'(rdy[1]), 0); tick();
    cyc(ISS); chk("fl_run", int'(st[1]), 0); chk("fl_rdy2", int'(rdy[1]), 1);
    chk("fl_nobub", int'(bub[1]), 0); tick();

    // Counter saturation on the 4-bit instance, then async clear.
    do_reset();
    v = ISS; v.exr = 0;
    for (int i = 0; i < 20; i++) begin cyc(v); tick(); end
    chk("sat_sc3", int'(sc1), 15);
    chk("sat_sc1", int'(sc0), 20);
    do_reset();

    // Reset in the middle of HAZ abandons the sequence.
    cyc(ISS); tick();
    cyc(LHZ); tick();
    chk("mid_haz", int'(st[1]), 1);
    do_reset();
    cyc(ISS); chk("post_rst_st", int'(st[1]), 0); chk("post_rst_rdy", int'(rdy[1]), 1);
    chk("post_rst_bub", int'(bub[1]), 0); tick();

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 63) == 0) begin
        do_reset();
      end else begin
        v.dv  = ($urandom_range(0, 99) < 85);
        v.s1  = 5'($urandom_range(0, 3));
        v.s2  = 5'($urandom_range(0, 3));
        v.u1  = 1'($urandom_range(0, 1));
        v.u2  = 1'($urandom_range(0, 1));
        v.mr  = 1'($urandom_range(0, 1));
        v.dst = 5'($urandom_range(0, 3));
        v.exr = ($urandom_range(0, 99) < 85);
        v.fl  = ($urandom_range(0, 99) < 6);
        cyc(v);
        tick();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_ctrl.md
ID_EX_CTRL -- requirements
Module: id_ex_ctrl

Interface
REQ-001 Parameter: LOAD_LAT, default 1, number of bubble cycles inserted per load-use hazard (legal 1..7).
REQ-002 Parameter: CNT_W, default 16, width of stall performance counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 dec_valid  input  1  decode stage holds a valid instruction.
REQ-006 dec_srcReg1 / dec_srcReg2  input  5 each  decoded source register indices.
REQ-007 dec_useRs1 / dec_useRs2  input  1 each  instruction actually reads the corresponding source.
REQ-008 ex_memRead  input  1  memRead_out of the ID/EX pipeline register.
REQ-009 ex_destReg  input  5  destReg_out of the ID/EX pipeline register.
REQ-010 ex_ready  input  1  execute stage can accept the ID/EX contents this cycle.
REQ-011 flush  input  1  kill decode and ID/EX contents (branch/exception redirect).
REQ-012 dec_ready  output  1  decode instruction is consumed this cycle (combinational).
REQ-013 idex_en  output  1  load enable for the ID/EX register (combinational).
REQ-014 idex_bubble  output  1  force all ID/EX control fields (regWrite, memRead, memWrite, memToReg, lwSw) to zero on load (combinational).
REQ-015 ex_valid  output  1  registered; ID/EX register holds a real instruction.
REQ-016 stall_cnt  output  CNT_W  registered saturating count of stalled decode cycles.
REQ-017 state  output  2  registered FSM state: 00 RUN, 01 HAZ, 10 FLUSH.

Function
REQ-018 Hazard term haz = dec_valid & ex_valid & ex_memRead & (ex_destReg != 0) & ((dec_useRs1 & dec_srcReg1 == ex_destReg) | (dec_useRs2 & dec_srcReg2 == ex_destReg)).
REQ-019 Per-cycle priority SHALL be: flush > ex_ready low > state HAZ/FLUSH > haz > normal issue.
REQ-020 flush=1 (any state): idex_en=1, idex_bubble=1, dec_ready=0; next ex_valid=0, next state FLUSH, hazard counter cleared.
REQ-021 ex_ready=0 without flush: idex_en=0, dec_ready=0, ex_valid, state and hazard counter held.
REQ-022 RUN, haz=1: idex_en=1, idex_bubble=1, dec_ready=0, next ex_valid=0; if LOAD_LAT>1 next state HAZ with counter=LOAD_LAT-1, else stay RUN.
REQ-023 HAZ: idex_en=1, idex_bubble=1, dec_ready=0, counter decrements each cycle; state returns to RUN on the cycle counter reaches 0 (total bubbles = LOAD_LAT).
REQ-024 FLUSH: lasts exactly one cycle; idex_en=1, idex_bubble=1, dec_ready=0; next state RUN.
REQ-025 RUN, haz=0: idex_en=1, idex_bubble=0, dec_ready=dec_valid; next ex_valid=dec_valid.
REQ-026 dec_ready SHALL never be 1 while dec_valid=0.
REQ-027 Whenever idex_en=1 and idex_bubble=1, next ex_valid SHALL be 0.
REQ-028 stall_cnt increments when dec_valid=1 and dec_ready=0, saturates at all-ones, never wraps.
REQ-029 Register x0 never causes a hazard; hazard check uses only ex_valid contents (a bubble never triggers a stall).

Reset
REQ-030 rst=1 SHALL immediately force state=RUN, ex_valid=0, stall_cnt=0, hazard counter=0, independent of clk.
REQ-031 Reset asserted mid-HAZ or mid-FLUSH SHALL abandon the sequence; first cycle after deassertion behaves as RUN.
REQ-032 During reset combinational outputs SHALL follow RUN-state rules with ex_valid=0.

Verification
REQ-033 Load x5 in EX (ex_valid=1, ex_memRead=1, ex_destReg=5), decode add using rs1=5, LOAD_LAT=1 -> one cycle idex_bubble=1, dec_ready=0, stall_cnt=1, then issue with dec_ready=1.
REQ-034 Same with LOAD_LAT=3 -> exactly 3 bubble cycles, state RUN->HAZ->HAZ->RUN, stall_cnt=3.
REQ-035 ex_memRead=1, ex_destReg=0, rs1=0 -> no stall; dec_ready=1 every cycle.
REQ-036 flush asserted in HAZ with counter=2 -> next cycle state FLUSH, ex_valid=0; following cycle RUN, no residual bubbles.
REQ-037 ex_ready=0 for 4 cycles with dec_valid=1 -> idex_en=0, ex_valid unchanged, stall_cnt +4; HAZ counter frozen if in HAZ.
REQ-038 CNT_W=4, 20 continuous stall cycles -> stall_cnt holds 15; rst pulse mid-count -> stall_cnt=0 asynchronously.
